// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/strobe inputs and scanned pin outputs of the display driver.
interface seg7_scan_driver_if #(parameter int DIGITS = 4);
    logic                load_i;
    logic [4*DIGITS-1:0] value_i;
    logic [DIGITS-1:0]   dp_i;
    logic                blank_lz_i;
    logic [7:0]          seg_o;
    logic [DIGITS-1:0]   an_o;
    logic                frame_done_o;
    modport master (output load_i, value_i, dp_i, blank_lz_i, input seg_o, an_o, frame_done_o);
    modport slave  (input load_i, value_i, dp_i, blank_lz_i, output seg_o, an_o, frame_done_o);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner with frame-synchronous commit,
// hex/BCD decode, per-digit decimal points and leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int GUARD          = 16,
    parameter bit HEX_EN         = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                pend_q, fd_q, slot_end, wrap, dark, blank, z;
    logic [4*DIGITS-1:0] pval_q, aval_q;
    logic [DIGITS-1:0]   pdp_q, adp_q, an_q, an_d, lz;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          nib;
    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'b1111_1100;
            4'h1: glyph = 8'b0110_0000;
            4'h2: glyph = 8'b1101_1010;
            4'h3: glyph = 8'b1111_0010;
            4'h4: glyph = 8'b0110_0110;
            4'h5: glyph = 8'b1011_0110;
            4'h6: glyph = 8'b1011_1110;
            4'h7: glyph = 8'b1110_0000;
            4'h8: glyph = 8'b1111_1110;
            4'h9: glyph = 8'b1110_0110;
            4'hA: glyph = 8'b1110_1110;
            4'hB: glyph = 8'b0011_1110;
            4'hC: glyph = 8'b1001_1100;
            4'hD: glyph = 8'b0111_1010;
            4'hE: glyph = 8'b1001_1110;
            default: glyph = 8'b1000_1110;
        endcase
    endfunction
    always_comb begin
        slot_end = cnt_q == CW'(DIV - 1);
        wrap     = slot_end && idx_q == IW'(DIGITS - 1);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
        z        = 1'b1;
        lz       = '0;
        // lz[i]: every active nibble from the MSD down to i is zero
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z     = z && aval_q[4*i +: 4] == 4'd0;
            lz[i] = z;
        end
        nib   = aval_q[4*idx_q +: 4];
        dark  = cnt_q < CW'(GUARD);
        blank = bus.blank_lz_i && idx_q != '0 && lz[idx_q];
        seg_d = dark ? 8'h00 :
                (!HEX_EN && nib > 4'd9) ? 8'h01 :
                blank ? {7'b0, adp_q[idx_q]} :
                glyph(nib) | {7'b0, adp_q[idx_q]};
        an_d  = dark ? '0 : DIGITS'(1) << idx_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            pval_q <= '0;
            pdp_q  <= '0;
            aval_q <= '0;
            adp_q  <= '0;
            seg_q  <= '0;
            an_q   <= '0;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            fd_q   <= wrap;
            pend_q <= wrap ? 1'b0 : pend_q | bus.load_i;
            if (bus.load_i) begin
                pval_q <= bus.value_i;
                pdp_q  <= bus.dp_i;
            end
            // a load in the wrap cycle bypasses pending so it is not deferred a whole frame
            if (wrap && (bus.load_i || pend_q)) begin
                aval_q <= bus.load_i ? bus.value_i : pval_q;
                adp_q  <= bus.load_i ? bus.dp_i : pdp_q;
            end
        end
    end
    assign bus.seg_o        = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign bus.an_o         = an_q ^ {DIGITS{AN_ACTIVE_LOW}};
    assign bus.frame_done_o = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: hex/active-high and BCD/active-low instances scanned in lockstep,
// with a queue of expected frames per instance.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4, DIV = 8, GUARD = 2;
    typedef logic [DIGITS-1:0][7:0] frame_t;
    typedef struct {
        logic [15:0] v1a, v1b, v2;
        logic [3:0]  dp1, dp2;
        int          at_a, at_b;
        frame_t      e1, e2;
    } vec_t;
    logic   clk = 1'b0, rst_n = 1'b0;
    int     total = 0, bad = 0, n;
    vec_t   vec [4];
    frame_t q1 [$], q2 [$];
    always #5 clk = ~clk;
    seg7_scan_driver_if #(.DIGITS(DIGITS)) b1 ();
    seg7_scan_driver_if #(.DIGITS(DIGITS)) b2 ();
    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .HEX_EN(1'b1),
                       .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
        d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .HEX_EN(1'b0),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ld, input logic [15:0] v1, input logic [15:0] v2,
                         input logic [3:0] p1, input logic [3:0] p2);
        b1.load_i = ld; b1.value_i = v1; b1.dp_i = p1;
        b2.load_i = ld; b2.value_i = v2; b2.dp_i = p2;
    endtask

    task automatic wait_fd(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            b1.load_i = 1'b0;
            b2.load_i = 1'b0;
            cnt++;
        end while (b1.frame_done_o !== 1'b1 && cnt < 100);
        chk("frame_done", {b1.frame_done_o, b2.frame_done_o}, 2'b11);
    endtask

    // checks cycles 1..31 after a frame_done sample, optionally loading entry v
    task automatic run_frame(input vec_t v, input bit has);
        frame_t     f1, f2;
        logic [7:0] es, es2;
        logic [3:0] ea;
        int         k, last;
        bit         lit;
        f1 = q1.pop_front();
        f2 = q2.pop_front();
        last = v.at_b != 0 ? v.at_b : v.at_a;
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            k   = (c - 1) / DIV;
            lit = (c - 1) % DIV >= GUARD;
            es  = lit ? f1[k] : 8'h00;
            es2 = lit ? f2[k] : 8'h00;
            ea  = lit ? 4'(1 << k) : 4'h0;
            chk("hex_slot", {b1.seg_o, b1.an_o, b1.frame_done_o}, {es, ea, 1'b0});
            chk("bcd_slot", {b2.seg_o, b2.an_o, b2.frame_done_o}, {~es2, ~ea, 1'b0});
            drive(0, 16'h0, 16'h0, 4'h0, 4'h0);
            if (has && c == v.at_a) drive(1, v.v1a, v.v2, v.dp1, v.dp2);
            if (has && v.at_b != 0 && c == v.at_b) drive(1, v.v1b, v.v2, v.dp1, v.dp2);
            if (has && c == last) begin
                q1.push_back(v.e1);
                q2.push_back(v.e2);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hex", {b1.seg_o, b1.an_o, b1.frame_done_o}, 13'h0);
        chk("rst_bcd_pins", {b2.seg_o, b2.an_o, b2.frame_done_o}, {8'hFF, 4'hF, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("post_rst", {b1.seg_o, b1.an_o}, c == 3 ? {8'hFC, 4'b0001} : 12'h0);
        end
        q1.delete();
        q2.delete();
        q1.push_back(32'hFCFC_FCFC);
        q2.push_back(32'h0000_00FC);
    endtask

    initial begin
        vec[0] = '{v1a:16'h1234, v1b:16'h0000, v2:16'h00A5, dp1:4'b0100, dp2:4'b0000,
                   at_a:5, at_b:0, e1:32'h60DB_F266, e2:32'h0000_01B6};
        vec[1] = '{v1a:16'h1111, v1b:16'h5678, v2:16'h0008, dp1:4'b0000, dp2:4'b0000,
                   at_a:4, at_b:20, e1:32'hB6BE_E0FE, e2:32'h0000_00FE};
        vec[2] = '{v1a:16'hABCD, v1b:16'h0000, v2:16'h0080, dp1:4'b0000, dp2:4'b1001,
                   at_a:31, at_b:0, e1:32'hEE3E_9C7A, e2:32'h0100_FEFD};
        vec[3] = '{v1a:16'hF0E9, v1b:16'h0000, v2:16'h0C07, dp1:4'b1111, dp2:4'b0010,
                   at_a:10, at_b:0, e1:32'h8FFD_9FE7, e2:32'h0001_FDE0};
        drive(0, 16'h0, 16'h0, 4'h0, 4'h0);
        b1.blank_lz_i = 1'b0;
        b2.blank_lz_i = 1'b1;
        do_reset();
        wait_fd(n);
        for (int i = 0; i < 4; i++) begin
            run_frame(vec[i], 1'b1);
            wait_fd(n);
            chk("fd_period", n, 1);
        end
        run_frame(vec[0], 1'b0);
        wait_fd(n);
        chk("fd_period", n, 1);
        // pending data queued just before a mid-frame reset must be discarded
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(c == 1, 16'h9999, 16'h0099, 4'hF, 4'hF);
        end
        do_reset();
        wait_fd(n);
        run_frame(vec[0], 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of seven-segment digits, the parametrised successor to the single-digit BCD decoder. It holds a multi-digit value in a shadow register and commits it only at frame boundaries, so a display never shows a half-updated number. Each frame it scans digits LSD→MSD with a programmable dwell and an anode-off guard interval, and supports hex or BCD decoding, per-digit decimal points and leading-zero blanking. It sits between the datapath that produces the value and the board's segment/anode pins.

## Interface
- `DIGITS`, 4: number of digits scanned, ≥1.
- `DIV`, 50000: clock cycles each digit is selected (dwell), ≥4.
- `GUARD`, 16: cycles at the start of each dwell with all anodes off; 0 ≤ GUARD < DIV.
- `HEX_EN`, 1: 1 = nibbles 10–15 render A,b,C,d,E,F; 0 = BCD only, 10–15 render the fault pattern.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg_out` at the pin.
- `AN_ACTIVE_LOW`, 1: 1 inverts `an_out` at the pin.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: 1-cycle strobe; captures `value`/`dp_in` into the pending register.
- `value` in 4*DIGITS: nibble i = digit i, nibble 0 = least significant.
- `dp_in` in DIGITS: decimal point per digit.
- `blank_lz` in 1: enables leading-zero blanking (sampled live).
- `seg_out` out 8: {a,b,c,d,e,f,g,dp}, bit7 = a, active-high before polarity.
- `an_out` out DIGITS: one-hot digit select, active-high before polarity.
- `frame_done` out 1: 1-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Glyphs, active-high {a..g,dp}: 0=1111_1100, 1=0110_0000, 2=1101_1010, 3=1111_0010, 4=0110_0110, 5=1011_0110, 6=1011_1110, 7=1110_0000, 8=1111_1110, 9=1110_0110, A=1110_1110, b=0011_1110, C=1001_1100, d=0111_1010, E=1001_1110, F=1000_1110. Fault pattern (invalid nibble when HEX_EN=0) = 0000_0001. dp bit is ORed with `dp_in` of that digit, except in the fault pattern, where it is always 1.
- Registers: prescaler `cnt` 0..DIV-1, digit index `idx` 0..DIGITS-1, pending value/dp plus a `pend` flag, and active value/dp.
- `load`=1 writes pending and sets `pend`. A later load before commit overwrites it; only the last load is used.
- Commit happens in the wrap cycle (cnt=DIV-1, idx=DIGITS-1):
  - `load` also high that cycle: active ← `value`/`dp_in` directly.
  - else if `pend`: active ← pending.
  - `pend` clears in either case.
- Leading-zero blanking: digit i (i ≥ 1) is blanked when `blank_lz`=1 and active nibbles DIGITS-1..i are all zero. Digit 0 is never blanked. A blanked digit drives segments a–g off; dp still follows `dp_in`.
- Anodes:
  - cnt < GUARD: all anodes off and segments all off.
  - otherwise: `an_out` one-hot at idx.
- Polarity inversion is applied as the last step, on the registered outputs.

## Timing
- Reset values (before polarity): cnt=0, idx=0, pend=0, pending=0, active=0, `seg_out`=0000_0000, `an_out`=0, `frame_done`=0. At the pins, after polarity: all segments off, all anodes off.
- `cnt` increments every cycle. At DIV-1 it returns to 0 and idx advances, with DIGITS-1 wrapping to 0.
- `seg_out`/`an_out` are registered, one cycle after the cnt/idx state they decode. The first lit cycle of digit k therefore follows the cycle where cnt=GUARD, idx=k.
- `frame_done` is registered and is high the cycle after the wrap cycle. Period = DIGITS·DIV cycles.
- Load-to-display latency: from 1 up to DIGITS·DIV cycles (until the next commit), plus one output-register cycle.
- `rst_n` asserted mid-frame: everything returns to reset values immediately, and pending data is lost. After deassertion, scanning restarts at digit 0, cnt=0.
- DIGITS=1: a wrap occurs every DIV cycles. GUARD=0: no dark interval.

## Test plan
(DIGITS=4, DIV=8, GUARD=2, HEX_EN=1, both polarities active-high unless stated.)
- **Reset:** assert `rst_n`=0 mid-scan → `seg_out`=0, `an_out`=0, `frame_done`=0 asynchronously. After release, the first lit slot is digit 0 showing 0 (1111_1100) with `an_out`=0001.
- **Scan/commit:** load value=16'h1234, dp_in=4'b0100 → after the next wrap, slots show digit0 "4"=0110_0110, digit1 "3"=1111_0010, digit2 "2"+dp=1101_1011, digit3 "1"=0110_0000. Each slot is lit 6 cycles after 2 dark cycles, and `frame_done` pulses every 32 cycles.
- **No tearing:** load 16'h1111, then load 16'h5678 mid-frame → the current frame still shows the old value. The next frame shows 5678 only; 1111 never appears.
- **Load in wrap cycle:** load 16'hABCD exactly at cnt=7, idx=3 → the next frame shows D=0111_1010, C=1001_1100, b=0011_1110, A=1110_1110.
- **BCD fault and blanking:** HEX_EN=0, value=16'h00A5, blank_lz=1 → digits 3 and 2 are blank (0000_0000), digit1 shows 0000_0001, digit0 shows "5"=1011_0110. Value 16'h0000 → only digit 0 lit, showing "0".
- **Polarity:** SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 → under reset, pins read 8'hFF and 4'hF. Digit 0 showing "8" drives `seg_out`=0000_0001 and `an_out`=1110.
